// File: rtl/uart_frame_rcv.sv
// 8N1 UART frame receiver: NBYTES payload bytes plus CRC-16/MODBUS (low, high), parallel payload out.
// Optional `FRAME_TIMEOUT_EN adds an idle timer that aborts a stalled partial frame.
module uart_frame_rcv #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int NBYTES       = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RXD,
  output logic [NBYTES*8-1:0] data,
  output logic                frame_done,
  output logic                crc_ok,
  output logic                frame_err,
  output logic                busy
);

  // state      | meaning
  // S_IDLE     | line idle, waiting for a falling edge
  // S_START    | half-bit wait, confirm start bit still low
  // S_DATA     | sampling 8 data bits, LSB first
  // S_STOP     | sampling stop bit
  // S_WAIT_HIGH| framing error seen, waiting for line to go high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int IW  = $clog2(NBYTES + 2);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shreg, sh_n;
  logic            byte_ok, stop_err, timeout;
  logic            rxd_m, rxd_s, rxd_d;
  logic [IW-1:0]   idx;
  logic [15:0]     crc, crc_base;
  logic [7:0]      rx_l;
  logic [NBYTES*8-1:0] shadow;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt != '0) ? cnt - CW'(1) : cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    byte_ok  = 1'b0;
    stop_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxd_d && !rxd_s) begin
          state_n = S_START;
          cnt_n   = CW'(DIV / 2 - 1);
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rxd_s) begin
            state_n = S_DATA;
            cnt_n   = CW'(DIV - 1);
            bit_n   = 3'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          sh_n  = {rxd_s, shreg[7:1]};
          cnt_n = CW'(DIV - 1);
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rxd_s) begin
            byte_ok = 1'b1;
            state_n = S_IDLE;
          end else begin
            stop_err = 1'b1;
            state_n  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxd_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  logic [TW-1:0] to_cnt;
  logic          to_run;

  assign to_run = (idx != '0) && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n || !to_run)
      to_cnt <= TW'(TO_CLKS - 1);
    else if (to_cnt != '0)
      to_cnt <= to_cnt - TW'(1);
  end

  assign timeout = to_run && (to_cnt == '0);
`else
  // Never fires; a partial frame waits until a stop-bit error or reset.
  assign timeout = (TIMEOUT_BITS < 0);
`endif

  assign crc_base = (idx == '0) ? 16'hFFFF : crc;
  assign busy     = (idx != '0) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      crc        <= 16'hFFFF;
      rx_l       <= '0;
      shadow     <= '0;
      data       <= '0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (stop_err || timeout) begin
        idx       <= '0;
        crc       <= 16'hFFFF;
        frame_err <= 1'b1;
      end else if (byte_ok) begin
        if (idx < IW'(NBYTES)) begin
          for (int k = 0; k < NBYTES; k++)
            if (idx == IW'(k)) shadow[k*8 +: 8] <= shreg;
          crc <= crc16_byte(crc_base, shreg);
          idx <= idx + IW'(1);
        end else if (idx == IW'(NBYTES)) begin
          rx_l <= shreg;
          idx  <= idx + IW'(1);
        end else begin
          frame_done <= 1'b1;
          crc_ok     <= ({shreg, rx_l} == crc);
          if ({shreg, rx_l} == crc) data <= shadow;
          idx <= '0;
        end
      end
    end
  end

endmodule

// File: doc/uart_frame_rcv.md
# uart_frame_rcv

- Receive-side counterpart of the frame transmitter: deserialises an 8N1 UART stream, assembles one frame of NBYTES payload bytes followed by a CRC16 (low byte, then high byte), checks the CRC and presents the payload as a parallel word.
- Sits directly downstream of the transmitter's TXD line, on the visualisation side of the DE2-115 link.
- Includes its own bit-level receiver, byte sequencer and CRC checker.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer, truncated) clocks per bit.
- NBYTES, 16, payload bytes per frame (1..16).
- TIMEOUT_BITS, 20, idle bit-times that abort a partial frame (used only with FRAME_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- RXD  in  1  serial input, idle high, asynchronous to clk.
- data  out  NBYTES*8  last CRC-good payload; byte k at data[k*8 +: 8], byte 0 received first.
- frame_done  out  1  one-cycle pulse at end of every complete frame.
- crc_ok  out  1  valid during frame_done: 1 = received CRC matches.
- frame_err  out  1  one-cycle pulse on stop-bit error or timeout abort.
- busy  out  1  high while a frame is partially received (byte index ≠ 0 or bit FSM not IDLE).

## Operation
- RXD passes through a 2-flop synchroniser, reset to 1; all logic uses the synchronised copy.
- Bit FSM:
  - IDLE: a falling edge starts a half-bit counter and moves to START.
  - START: sample at DIV/2. If low, go to DATA; if high, it is a glitch and returns to IDLE.
  - DATA: 8 samples, each DIV clocks apart, shifted in LSB first.
  - STOP: sample after a further DIV. If high, the byte is accepted and the FSM returns to IDLE immediately, so back-to-back bytes are supported. If low, frame_err pulses, the byte index clears, and the FSM waits for RXD high before returning to IDLE.
- Byte sequencer (index 0..NBYTES+1):
  - Indices 0..NBYTES-1 write a shadow payload register and feed the CRC.
  - Index NBYTES captures the received CRC low byte.
  - Index NBYTES+1 captures the high byte, then the frame completes and the index returns to 0.
- CRC: CRC-16/MODBUS. Reflected polynomial 0xA001, init 0xFFFF, no final XOR, computed over payload bytes only. It re-initialises to 0xFFFF whenever the index is 0 and a byte is accepted at index 0, on reset, and on any abort.
- Frame completion:
  - crc_ok = ({rx_H, rx_L} == crc).
  - If crc_ok, the shadow payload is copied to data.
  - If not, data keeps its previous value.
- Reset values: data 0, frame_done 0, crc_ok 0, frame_err 0, busy 0, index 0, FSM IDLE.
- Reset asserted mid-byte or mid-frame discards everything. Reception restarts only on the next falling edge seen after rst_n is released.

## Timing
- RXD to internal sample: 2 clk of synchroniser delay.
- frame_done and crc_ok assert on the clk after the final stop-bit sample.
- data updates on the same edge that frame_done asserts; data is stable from that edge onward.
- frame_err is asserted on the clk after the failing stop sample or the timeout expiry.
- frame_done and frame_err never assert in the same cycle.
- Tolerates ±2% baud mismatch (mid-bit sampling).
- Bytes may be separated by any idle gap. Without the timeout feature, the gap is unbounded.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - An idle counter runs while index ≠ 0 and the bit FSM is IDLE.
  - After TIMEOUT_BITS*DIV clocks, frame_err pulses, the index clears and the CRC re-initialises. This resynchronises after a lost byte.
- FRAME_TIMEOUT_EN undefined:
  - No counter is built and a partial frame waits indefinitely.
  - The only resync paths are a stop-bit error or reset.

## Test plan
- NBYTES=9; send ASCII "123456789" then 0x37, 0x4B → frame_done=1, crc_ok=1, data byte0=0x31 … byte8=0x39.
- Same frame with CRC bytes 0x37, 0x4C → frame_done=1, crc_ok=0, data unchanged from the previous good frame.
- Byte 3 sent with stop bit = 0 → frame_err pulse, busy=0 after the line returns high. The next full good frame gives crc_ok=1.
- 0.25-bit low glitch on idle RXD → no byte accepted, busy stays 0.
- Assert rst_n=0 for 1 clk after payload byte 5 → all outputs 0. A subsequent complete good frame gives crc_ok=1.
- With FRAME_TIMEOUT_EN, stop after 4 bytes and idle for 21 bit-times → frame_err pulse at 20 bit-times, busy=0. A following good frame gives crc_ok=1.
